// File: rtl/divide_rv.sv
// rtl/divide_rv.sv - iterative RV32M divide unit (DIV/DIVU/REM/REMU) with ROB tag and CDB hold
// Restoring divider on operand magnitudes; signs applied in FIX, special cases and early-out bypass the loop.
module divide_rv #(
  parameter int WIDTH          = 32,
  parameter int TAG_W          = 4,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] rs_rob_entry,
  output logic             valid_out,
  input  logic             yumi_in,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_rob_entry
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ITER, S_FIX, S_SPECIAL, S_EARLY, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             a_neg_q, b_neg_q;
  logic [WIDTH-1:0] a_mag_q, b_mag_q, dvd_q;
  logic [WIDTH-1:0] rem_q, quo_q, result_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             signed_in, a_neg_in, b_neg_in;
  logic             is_zero, is_ovf, is_early;
  logic [WIDTH:0]   t_c;
  logic [WIDTH-1:0] r_c, q_c;
  logic [WIDTH-1:0] quo_fix, rem_fix, fix_result, special_result, early_result;

  assign accept    = valid_in && (state_q == S_IDLE) && !flush;
  assign signed_in = !op[0];
  assign a_neg_in  = signed_in && dividend[WIDTH-1];
  assign b_neg_in  = signed_in && divisor[WIDTH-1];

  // Classification uses the latched magnitudes, so it happens in LOAD
  assign is_zero  = (b_mag_q == '0);
  assign is_ovf   = !op_q[0] && a_neg_q && b_neg_q && (a_mag_q == MIN_VAL) && (b_mag_q == WIDTH'(1));
  assign is_early = (b_mag_q > a_mag_q);

  always_comb begin
    r_c = rem_q;
    q_c = quo_q;
    t_c = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      t_c = {r_c, q_c[WIDTH-1]};
      q_c = {q_c[WIDTH-2:0], 1'b0};
      if (t_c >= {1'b0, b_mag_q}) begin
        r_c    = t_c[WIDTH-1:0] - b_mag_q;
        q_c[0] = 1'b1;
      end else begin
        r_c = t_c[WIDTH-1:0];
      end
    end
  end

  assign quo_fix        = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
  assign rem_fix        = a_neg_q ? -rem_q : rem_q;
  assign fix_result     = op_q[1] ? rem_fix : quo_fix;
  assign special_result = is_zero ? (op_q[1] ? dvd_q : '1) : (op_q[1] ? '0 : MIN_VAL);
  assign early_result   = op_q[1] ? dvd_q : '0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (accept) state_d = S_LOAD;
        S_LOAD: begin
          if (is_zero || is_ovf) state_d = S_SPECIAL;
          else if (is_early)     state_d = S_EARLY;
          else                   state_d = S_ITER;
        end
        S_ITER:    if (cnt_q == '0) state_d = S_FIX;
        S_FIX,
        S_SPECIAL,
        S_EARLY:   state_d = S_DONE;
        S_DONE:    if (yumi_in) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready         = (state_q == S_IDLE);
    valid_out     = (state_q == S_DONE);
    out_result    = valid_out ? result_q : '0;
    out_rob_entry = valid_out ? tag_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      tag_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op;
            tag_q   <= rs_rob_entry;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            a_mag_q <= a_neg_in ? -dividend : dividend;
            b_mag_q <= b_neg_in ? -divisor : divisor;
            dvd_q   <= dividend;
          end
        end
        S_LOAD: begin
          rem_q <= '0;
          quo_q <= a_mag_q;
          cnt_q <= CNT_W'(ITERS - 1);
        end
        S_ITER: begin
          rem_q <= r_c;
          quo_q <= q_c;
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX:     result_q <= fix_result;
        S_SPECIAL: result_q <= special_result;
        S_EARLY:   result_q <= early_result;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_rv.sv
// tb/tb_divide_rv.sv - scoreboard bench for divide_rv at BITS_PER_CYCLE 1 and 4 side by side
module tb_divide_rv;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in, yumi_in;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic [3:0]  tag;
  logic        ready, valid_out, ready4, valid_out4;
  logic [31:0] out_result, out_result4;
  logic [3:0]  out_rob, out_rob4;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp4_q[$];

  always #5 clk = ~clk;

  divide_rv #(.WIDTH(32), .TAG_W(4), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready(ready),
    .op(op), .dividend(dividend), .divisor(divisor), .rs_rob_entry(tag),
    .valid_out(valid_out), .yumi_in(yumi_in), .out_result(out_result), .out_rob_entry(out_rob)
  );

  divide_rv #(.WIDTH(32), .TAG_W(4), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready(ready4),
    .op(op), .dividend(dividend), .divisor(divisor), .rs_rob_entry(tag),
    .valid_out(valid_out4), .yumi_in(yumi_in), .out_result(out_result4), .out_rob_entry(out_rob4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] golden(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] expv,
                        input int lat, input int lat4, input int hold, input bit noise);
    logic [35:0] e;
    int cyc;
    bit got, got4;
    exp_q.push_back({t, expv});
    exp4_q.push_back({t, expv});
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_before_accept got %b want 1", ready); end
    op = o; dividend = a; divisor = b; tag = t; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
    cyc = 0; got = 0; got4 = 0;
    while (!got && cyc < 200) begin
      if (noise) begin
        valid_in = (cyc % 2) == 0;
        dividend = $urandom; divisor = $urandom; op = 2'($urandom); tag = 4'($urandom);
      end
      tick;
      cyc++;
      if (valid_out4 && !got4) begin
        got4 = 1;
        e = exp4_q.pop_front();
        checks++;
        if ({out_rob4, out_result4} !== e) begin
          errors++; $display("FAIL result4 op=%0d a=%h b=%h got %h want %h", o, a, b, {out_rob4, out_result4}, e);
        end
        if (lat4 >= 0) begin
          checks++;
          if (cyc != lat4) begin errors++; $display("FAIL latency4 op=%0d a=%h b=%h got %0d want %0d", o, a, b, cyc, lat4); end
        end
      end
      if (valid_out && !got) begin
        got = 1;
        e = exp_q.pop_front();
        checks++;
        if ({out_rob, out_result} !== e) begin
          errors++; $display("FAIL result op=%0d a=%h b=%h got %h want %h", o, a, b, {out_rob, out_result}, e);
        end
        if (lat >= 0) begin
          checks++;
          if (cyc != lat) begin errors++; $display("FAIL latency op=%0d a=%h b=%h got %0d want %0d", o, a, b, cyc, lat); end
        end
      end else if (!got && noise) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", ready); end
      end
    end
    valid_in = 1'b0;
    if (!got) begin
      errors++; void'(exp_q.pop_front());
      $display("FAIL timeout op=%0d a=%h b=%h got no valid_out want result", o, a, b);
    end
    if (!got4) begin
      errors++; void'(exp4_q.pop_front());
      $display("FAIL timeout4 op=%0d a=%h b=%h got no valid_out want result", o, a, b);
    end
    for (int i = 0; i < hold; i++) begin
      tick;
      checks++;
      if (valid_out !== 1'b1 || out_result !== expv || out_rob !== t) begin
        errors++; $display("FAIL hold cycle %0d got v=%b r=%h tag=%h want v=1 r=%h tag=%h", i, valid_out, out_result, out_rob, expv, t);
      end
    end
    yumi_in = 1'b1;
    tick;
    yumi_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || valid_out4 !== 1'b0 || out_result !== 32'd0 || out_rob !== 4'd0 || ready !== 1'b1) begin
      errors++; $display("FAIL after_yumi got v=%b v4=%b r=%h tag=%h rdy=%b want 0 0 0 0 1", valid_out, valid_out4, out_result, out_rob, ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; yumi_in = 1'b0;
    op = 2'd0; dividend = '0; divisor = '0; tag = '0;
    tick; tick;
    reset = 1'b0;
    tick;
    checks++;
    if (ready !== 1'b1 || ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b %b want 1 1", ready, ready4); end
    checks++;
    if (valid_out !== 1'b0 || valid_out4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b %b want 0 0", valid_out, valid_out4); end
    checks++;
    if (out_result !== 32'd0 || out_rob !== 4'd0) begin errors++; $display("FAIL reset_outputs got %h %h want 0 0", out_result, out_rob); end
  endtask

  task automatic test_directed;
    run_op(2'b00, 32'd100,         32'd3,          4'd5,  32'd33,          34, 10, 0, 0);
    run_op(2'b00, -32'sd100,       32'd3,          4'd1,  32'hFFFF_FFDF,   34, 10, 0, 0);
    run_op(2'b10, -32'sd100,       32'd3,          4'd2,  32'hFFFF_FFFF,   34, 10, 0, 0);
    run_op(2'b10, 32'd100,         -32'sd3,        4'd3,  32'd1,           34, 10, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF,   32'd10,         4'd4,  32'd429496729,   34, 10, 0, 0);
    run_op(2'b00, 32'h8000_0000,   32'hFFFF_FFFF,  4'd6,  32'h8000_0000,   2,  2,  0, 0);
    run_op(2'b10, 32'h8000_0000,   32'hFFFF_FFFF,  4'd7,  32'd0,           2,  2,  0, 0);
    run_op(2'b01, 32'd12345,       32'd0,          4'd8,  32'hFFFF_FFFF,   2,  2,  0, 0);
    run_op(2'b11, 32'd12345,       32'd0,          4'd9,  32'd12345,       2,  2,  0, 0);
    run_op(2'b00, -32'sd5,         32'd0,          4'd10, 32'hFFFF_FFFF,   2,  2,  0, 0);
    run_op(2'b10, -32'sd5,         32'd0,          4'd11, 32'hFFFF_FFFB,   2,  2,  0, 0);
    run_op(2'b11, 32'd7,           32'd9,          4'd12, 32'd7,           2,  2,  0, 0);
    run_op(2'b00, 32'd5,           -32'sd7,        4'd13, 32'd0,           2,  2,  0, 0);
    run_op(2'b10, -32'sd5,         32'd7,          4'd14, 32'hFFFF_FFFB,   2,  2,  0, 0);
    run_op(2'b00, 32'h8000_0000,   32'd2,          4'd15, 32'hC000_0000,   34, 10, 0, 0);
    run_op(2'b01, 32'd5,           32'd5,          4'd0,  32'd1,           34, 10, 0, 0);
    run_op(2'b01, 32'd1000,        32'd7,          4'd3,  32'd142,         34, 10, 0, 0);
  endtask

  task automatic test_hold_and_busy;
    run_op(2'b00, 32'd100, 32'd3, 4'd9, 32'd33, 34, 10, 10, 1);
  endtask

  task automatic start_raw(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; dividend = a; divisor = b; tag = 4'd7; valid_in = 1'b1;
    tick;
    valid_in = 1'b0;
  endtask

  task automatic test_flush;
    bit seen;
    start_raw(2'b01, 32'hFFFF_FFFF, 32'd3);
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checks++;
    if (ready !== 1'b1 || ready4 !== 1'b1 || valid_out !== 1'b0) begin
      errors++; $display("FAIL flush_idle got rdy=%b rdy4=%b v=%b want 1 1 0", ready, ready4, valid_out);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (valid_out || valid_out4) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_no_result got valid_out after flush want none"); end
    run_op(2'b01, 32'd1000, 32'd7, 4'd2, 32'd142, 34, 10, 0, 0);
  endtask

  task automatic test_reset_mid;
    start_raw(2'b00, 32'h7FFF_0000, 32'd3);
    repeat (12) tick;
    reset = 1'b1;
    tick;
    checks++;
    if (ready !== 1'b1 || valid_out !== 1'b0 || out_result !== 32'd0 || out_rob !== 4'd0 || ready4 !== 1'b1) begin
      errors++; $display("FAIL reset_mid got rdy=%b v=%b r=%h tag=%h want 1 0 0 0", ready, valid_out, out_result, out_rob);
    end
    reset = 1'b0;
    tick;
    run_op(2'b10, 32'd1000, 32'd7, 4'd4, 32'd6, 34, 10, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, b, aa, ab, ev;
    logic [1:0]  o;
    bit fast;
    for (int n = 0; n < 500; n++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        3: b = $urandom_range(1, 255) ^ {32{b[31]}};
        default: ;
      endcase
      ev = golden(o, a, b);
      aa = (!o[0] && a[31]) ? -a : a;
      ab = (!o[0] && b[31]) ? -b : b;
      fast = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ab > aa);
      run_op(o, a, b, 4'(n), ev, fast ? 2 : 34, fast ? 2 : 10, 0, 0);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold_and_busy;
    test_flush;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
